// File: rtl/run_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : run_sequencer_if
//  Description : Control bus between the run sequencer and the single-cycle
//                core. The sequencer drives start and the program address
//                window. The core returns done.
//  Revision    : 1.0 - initial release
// ============================================================================
interface run_sequencer_if #(
  parameter int PC_BITS = 9
);
  logic               core_start;
  logic [PC_BITS-1:0] core_start_addr;
  logic [PC_BITS-1:0] core_done_addr;
  logic               core_done;

  // Sequencer side
  modport master (
    output core_start,
    output core_start_addr,
    output core_done_addr,
    input  core_done
  );

  // Core side
  modport slave (
    input  core_start,
    input  core_start_addr,
    input  core_done_addr,
    output core_done
  );
endinterface
`default_nettype wire

// File: rtl/run_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : run_sequencer
//  Description : Runs NUM_PROGS core programs back-to-back. It launches each
//                program, counts the cycles the program runs, aborts a
//                program that exceeds the timeout, and reports one result
//                per program.
//  Revision    : 1.0 - initial release
// ============================================================================
module run_sequencer #(
  parameter int PC_BITS    = 9,
  parameter int NUM_PROGS  = 3,
  parameter int IDX_BITS   = 2,
  parameter int CYCLE_BITS = 16,
  parameter int START_CYC  = 2
) (
  input  wire logic                           clock,
  input  wire logic                           reset_n,
  input  wire logic                           go,
  input  wire logic [NUM_PROGS*PC_BITS-1:0]   start_addr_tbl,
  input  wire logic [NUM_PROGS*PC_BITS-1:0]   done_addr_tbl,
  input  wire logic [CYCLE_BITS-1:0]          timeout_limit,
  run_sequencer_if.master                     core,
  output logic      [IDX_BITS-1:0]            prog_idx,
  output logic      [CYCLE_BITS-1:0]          cycle_count,
  output logic                                result_valid,
  output logic                                result_timeout,
  output logic                                busy,
  output logic                                all_done
);

  localparam logic [2:0] C_IDLE   = 3'd0;
  localparam logic [2:0] C_LAUNCH = 3'd1;
  localparam logic [2:0] C_RUN    = 3'd2;
  localparam logic [2:0] C_REPORT = 3'd3;
  localparam logic [2:0] C_FINISH = 3'd4;

  localparam int SCW = (START_CYC > 1) ? $clog2(START_CYC) : 1;
  localparam logic [SCW-1:0]      C_START_LAST = SCW'(START_CYC - 1);
  localparam logic [IDX_BITS-1:0] C_LAST_IDX   = IDX_BITS'(NUM_PROGS - 1);

  logic [2:0]            state_q, state_d;
  logic [IDX_BITS-1:0]   prog_idx_q, prog_idx_d;
  logic [CYCLE_BITS-1:0] cycle_count_q, cycle_count_d;
  logic [SCW-1:0]        start_cnt_q, start_cnt_d;
  logic                  flag_q, flag_d;

  logic [PC_BITS-1:0] start_entry [NUM_PROGS];
  logic [PC_BITS-1:0] done_entry  [NUM_PROGS];

  // Unpack the flat address tables into per-program entries.
  for (genvar k = 0; k < NUM_PROGS; k++) begin : g_tbl
    assign start_entry[k] = start_addr_tbl[k*PC_BITS +: PC_BITS];
    assign done_entry[k]  = done_addr_tbl[k*PC_BITS +: PC_BITS];
  end

  // Look up the address window of the current program in the tables.
  // The lookup is written as a compare loop so an index that is out of range
  // falls back to entry 0.
  always_comb begin
    core.core_start_addr = start_entry[0];
    core.core_done_addr  = done_entry[0];
    for (int k = 1; k < NUM_PROGS; k++) begin
      if (prog_idx_q == IDX_BITS'(k)) begin
        core.core_start_addr = start_entry[k];
        core.core_done_addr  = done_entry[k];
      end
    end
  end

  // Next-state logic: launch, run, report, and advance to the next program.
  always_comb begin
    state_d       = state_q;
    prog_idx_d    = prog_idx_q;
    cycle_count_d = cycle_count_q;
    start_cnt_d   = start_cnt_q;
    flag_d        = flag_q;
    case (state_q)
      C_IDLE, C_FINISH: begin
        if (go) begin
          prog_idx_d    = '0;
          cycle_count_d = '0;
          start_cnt_d   = '0;
          flag_d        = 1'b0;
          state_d       = C_LAUNCH;
        end
      end
      C_LAUNCH: begin
        // The core may still assert done from the previous program, so
        // done is ignored until the start pulse has been fully delivered.
        if (start_cnt_q == C_START_LAST) begin
          start_cnt_d = '0;
          state_d     = C_RUN;
        end else begin
          start_cnt_d = start_cnt_q + 1'b1;
        end
      end
      C_RUN: begin
        if (core.core_done) begin
          flag_d  = 1'b0;
          state_d = C_REPORT;
        end else if ((timeout_limit != '0) && (cycle_count_q == timeout_limit)) begin
          flag_d  = 1'b1;
          state_d = C_REPORT;
        end else if (cycle_count_q != '1) begin
          cycle_count_d = cycle_count_q + 1'b1;
        end
      end
      C_REPORT: begin
        if (prog_idx_q == C_LAST_IDX) begin
          state_d = C_FINISH;
        end else begin
          prog_idx_d    = prog_idx_q + 1'b1;
          cycle_count_d = '0;
          start_cnt_d   = '0;
          state_d       = C_LAUNCH;
        end
      end
      default: state_d = C_IDLE;
    endcase
  end

  // State registers. Reset is asynchronous, so the outputs decoded from the
  // state drop immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= C_IDLE;
      prog_idx_q    <= '0;
      cycle_count_q <= '0;
      start_cnt_q   <= '0;
      flag_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      prog_idx_q    <= prog_idx_d;
      cycle_count_q <= cycle_count_d;
      start_cnt_q   <= start_cnt_d;
      flag_q        <= flag_d;
    end
  end

  // Status outputs are decoded from the state. The timeout flag is only
  // exposed while the result is valid.
  always_comb begin
    core.core_start = (state_q == C_LAUNCH);
    result_valid    = (state_q == C_REPORT);
    result_timeout  = (state_q == C_REPORT) && flag_q;
    busy            = (state_q == C_LAUNCH) || (state_q == C_RUN) || (state_q == C_REPORT);
    all_done        = (state_q == C_FINISH);
    prog_idx        = prog_idx_q;
    cycle_count     = cycle_count_q;
  end

endmodule
`default_nettype wire
